// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
package addsub_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half-adder cells and an OR of their carries.
module full_adder_bit (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic sum_o,
   output logic carry_o
);

   logic ha0_sum_s;
   logic ha0_carry_s;
   logic ha1_carry_s;

   // First half adder combines the two operand bits
   assign ha0_sum_s   = a_i ^ b_i;
   assign ha0_carry_s = a_i & b_i;

   // Second half adder folds in the incoming carry
   assign sum_o       = ha0_sum_s ^ c_i;
   assign ha1_carry_s = ha0_sum_s & c_i;

   // Either half adder may generate the outgoing carry
   assign carry_o     = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice walks the operands
// LSB first, one bit per clock, and publishes the result with a done pulse.
module serial_addsub_ctrl
   import addsub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o,
   output logic             overflow_o
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_r;
   state_t             next_state_s;
   logic               load_s;
   logic               last_s;
   logic [WIDTH-1:0]   a_sh_r;
   logic [WIDTH-1:0]   b_sh_r;
   logic [WIDTH-1:0]   r_sh_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               carry_r;
   logic               sum_s;
   logic               fa_carry_s;
   logic               busy_r;
   logic               done_r;
   logic [WIDTH-1:0]   result_r;
   logic               carry_out_r;
   logic               overflow_r;

   // The single shared adder slice
   full_adder_bit u_fa (
      .a_i     (a_sh_r[0]),
      .b_i     (b_sh_r[0]),
      .c_i     (carry_r),
      .sum_o   (sum_s),
      .carry_o (fa_carry_s)
   );

   assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

   // Next-state decode and operand-load request
   always_comb begin
      next_state_s = state_r;
      load_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               next_state_s = ST_RUN;
               load_s       = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start_i) begin
               next_state_s = ST_RUN;
               load_s       = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath shifting and result publication
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= ST_IDLE;
         a_sh_r      <= '0;
         b_sh_r      <= '0;
         r_sh_r      <= '0;
         cnt_r       <= '0;
         carry_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         result_r    <= '0;
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == ST_RUN);
         done_r  <= (next_state_s == ST_DONE);
         if (load_s) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1
            a_sh_r  <= a_i;
            b_sh_r  <= sub_i ? ~b_i : b_i;
            carry_r <= sub_i;
            cnt_r   <= '0;
         end else if (state_r == ST_RUN) begin
            a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            r_sh_r  <= {sum_s, r_sh_r[WIDTH-1:1]};
            carry_r <= fa_carry_s;
            cnt_r   <= cnt_r + CNT_W'(1);
            if (last_s) begin
               // carry_r here is the carry into the MSB
               result_r    <= {sum_s, r_sh_r[WIDTH-1:1]};
               carry_out_r <= fa_carry_s;
               overflow_r  <= carry_r ^ fa_carry_s;
            end else begin
               result_r    <= result_r;
            end
         end else begin
            a_sh_r <= a_sh_r;
         end
      end
   end

   assign busy_o     = busy_r;
   assign done_o     = done_r;
   assign result_o   = result_r;
   assign carry_o    = carry_out_r;
   assign overflow_o = overflow_r;

endmodule
